ifetch_unit: RTL

- Instruction fetch stage sitting directly upstream of the main decoder.
- Holds the PC and issues requests to instruction memory over a req/ready handshake.
- Captures the returned word into an instruction register and presents instr/op (instr[31:26]) to the decoder with a valid flag.
- Computes the next PC from downstream branch/jump resolution, and supports a flush/redirect that may arrive mid-request.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/ifetch_unit_pc_next_sel.sv | 27 ++
 rtl/ifetch_unit.sv | 95 +++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the fetch stage, the main decoder and their benches.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    DROP  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // Instruction addresses are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_unit_pc_next_sel.sv
// Next-PC priority mux: redirect, then jump, then taken branch, then sequential.
module pc_next_sel
  import mips_pkg::*;
(
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] pcplus4,
  output logic [31:0] next_pc
);

  // Select the highest-priority source and force word alignment.
  always_comb begin
    next_pc = pcplus4;
    if (flush)
      next_pc = redirect_pc;
    else if (jump)
      next_pc = jump_target;
    else if (branch_taken)
      next_pc = branch_target;
    next_pc = word_align(next_pc);
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC, imem handshake, instruction register, redirect.
module ifetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic        instr_valid,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic [31:0] pcplus4
);

  localparam logic [31:0] RESET_PC_AL = word_align(RESET_PC);

  fetch_state_e state;
  logic [31:0]  req_addr;
  logic [31:0]  next_pc;

  assign pcplus4   = pc + 32'd4;
  assign imem_req  = (state == FETCH) || (state == DROP);
  assign imem_addr = req_addr;
  assign op        = instr[31:26];

  // Redirect wins over control flow; jump/branch only matter on an accept in VALID.
  pc_next_sel u_pc_next_sel (
    .flush         (flush),
    .redirect_pc   (redirect_pc),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pcplus4       (pcplus4),
    .next_pc       (next_pc)
  );

  // Fetch FSM: DROP keeps the in-flight request stable and discards its data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC_AL;
      req_addr    <= RESET_PC_AL;
      instr       <= '0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (flush) begin
            pc <= next_pc;
            if (imem_ready)
              req_addr <= next_pc;
            else
              state <= DROP;
          end else if (imem_ready) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= VALID;
          end
        end
        VALID: begin
          if (flush || !stall) begin
            pc          <= next_pc;
            req_addr    <= next_pc;
            instr_valid <= 1'b0;
            state       <= FETCH;
          end
        end
        DROP: begin
          if (flush)
            pc <= next_pc;
          if (imem_ready) begin
            req_addr <= flush ? next_pc : pc;
            state    <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
